// File: rtl/reload_down_counter.sv
// Loadable down counter: counts load_value..0, pulses tc on expiry, then reloads or stops.
// All outputs registered (one-edge latency from inputs); no flow control, enable simply holds state.
module reload_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;

  logic expire;
  assign expire = (state_q == RUN) && enable && (count_q == ZERO);

  // State register; all outputs are captured here too so nothing combinational reaches a port.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (expire && !auto_reload) state_d = DONE;
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Load beats expiry, so a load on the terminal edge suppresses that tc.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
    end else if (state_q == RUN && enable) begin
      if (count_q == ZERO) begin
        tc_d = 1'b1;
        if (auto_reload) count_d = reload_q;
      end else begin
        count_d = count_q - ONE;
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_reload_down_counter.sv
// Directed bench for reload_down_counter (WIDTH=4): one-shot, auto-reload, gating, corners, collisions.
module tb_reload_down_counter;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tc;

  int checks = 0;
  int errors = 0;

  int gate_cnt [10] = '{3, 3, 2, 2, 1, 1, 0, 0, 0, 0};
  int gate_tc  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  reload_down_counter #(.WIDTH(4)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .auto_reload(auto_reload),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int b, input int d, input int t);
    check({tag, ".count"}, 32'(count), c);
    check({tag, ".busy"},  32'(busy),  b);
    check({tag, ".done"},  32'(done),  d);
    check({tag, ".tc"},    32'(tc),    t);
  endtask

  initial begin
    // Reset held with a load pending: clear must win.
    clear_n = 1'b0; load = 1'b1; load_value = 4'd9; enable = 1'b0; auto_reload = 1'b0;
    step();
    step();
    check_all("reset", 0, 0, 0, 0);

    // One-shot from 5.
    clear_n = 1'b1; load = 1'b1; load_value = 4'd5; enable = 1'b1; auto_reload = 1'b0;
    step();
    load = 1'b0;
    check_all("os_load", 5, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_all("os_dec", 5 - i, 1, 0, 0);
    end
    step();
    check_all("os_expire", 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_all("os_hold", 0, 0, 1, 0);
    end

    // Auto-reload from 3: period of 4 enabled edges.
    load = 1'b1; load_value = 4'd3; auto_reload = 1'b1; enable = 1'b1;
    step();
    load = 1'b0;
    check_all("ar_load", 3, 1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      check_all("ar_run", 3 - (i % 4), 1, 0, (i % 4 == 0) ? 1 : 0);
    end

    // Enable gating from 4: expiry on the 5th enabled edge.
    load = 1'b1; load_value = 4'd4; auto_reload = 1'b0; enable = 1'b1;
    step();
    load = 1'b0;
    check_all("gate_load", 4, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      enable = (i % 2 == 0);
      step();
      check("gate.count", 32'(count), gate_cnt[i]);
      check("gate.tc",    32'(tc),    gate_tc[i]);
    end
    check_all("gate_end", 0, 0, 1, 0);

    // Load 0 in auto-reload: tc stays high every enabled cycle.
    load = 1'b1; load_value = 4'd0; auto_reload = 1'b1; enable = 1'b1;
    step();
    load = 1'b0;
    check_all("zero_load", 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_all("zero_run", 0, 1, 0, 1);
    end

    // Max load 15, one-shot: 16 enabled edges, no wrap.
    load = 1'b1; load_value = 4'd15; auto_reload = 1'b0; enable = 1'b1;
    step();
    load = 1'b0;
    check_all("max_load", 15, 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step();
      check_all("max_dec", 15 - i, 1, 0, 0);
    end
    step();
    check_all("max_expire", 0, 0, 1, 1);
    step();
    check_all("max_nowrap", 0, 0, 1, 0);

    // Load coincident with the expiry edge.
    load = 1'b1; load_value = 4'd2; auto_reload = 1'b0; enable = 1'b1;
    step();
    load = 1'b0;
    step();
    check_all("col_1", 1, 1, 0, 0);
    step();
    check_all("col_0", 0, 1, 0, 0);
    load = 1'b1; load_value = 4'd7;
    step();
    load = 1'b0;
    check_all("col_load", 7, 1, 0, 0);

    // Count down to 2, then clear mid-count.
    for (int i = 1; i <= 5; i++) begin
      step();
      check("clr_pre.count", 32'(count), 7 - i);
    end
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    check_all("clr_mid", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("clr_norestart", 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
